// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave with a local 16-bit register file: 16b command + 16b data frames,
// SCLK/MOSI/CS_N oversampled in the clk domain, write/read strobes towards the host side.
module spi_slave_regfile #(
  parameter logic [2:0] DEV_ID      = 3'd0,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [7:0]  host_addr,
  output logic [15:0] host_rdata,
  output logic        wr_strobe,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_strobe,
  output logic        frame_err,
  output logic        busy
);

  localparam int             AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0]     NREGS    = 9'(NUM_REGS);
  localparam logic [7:0]     INIT_CYC = 8'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_CS} state_t;

  state_t                 r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
  logic                   r_sclk_prev, r_cs_prev;
  logic [7:0]             r_init_cnt;
  logic                   r_armed;
  logic [5:0]             r_bit_cnt;
  logic [15:0]            r_cmd_sr, r_rx_sr, r_tx_sr;
  logic                   r_is_read;
  logic [15:0]            r_regs [NUM_REGS];

  logic w_sclk, w_mosi, w_cs_n, w_rise, w_fall, w_cs_assert, w_cs_deassert;
  logic w_start, w_abort, w_end, w_shift_cmd, w_shift_data, w_decode, w_tx_shift, w_commit;
  logic w_sel, w_sel_read, w_cmd_inrange, w_host_inrange, w_unused;
  logic [7:0]  w_cmd_addr;
  logic [15:0] w_cmd_rdata;

  assign w_sclk        = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi        = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_n        = r_cs_sync[SYNC_STAGES-1];
  assign w_rise        = w_sclk & ~r_sclk_prev;
  assign w_fall        = ~w_sclk & r_sclk_prev;
  assign w_cs_assert   = r_cs_prev & ~w_cs_n;
  assign w_cs_deassert = ~r_cs_prev & w_cs_n;

  // Global frames select every slave, but a global read would collide on MISO.
  assign w_cmd_addr     = r_cmd_sr[10:3];
  assign w_sel          = (((r_cmd_sr[15:14] == 2'b00) && (r_cmd_sr[13:11] == DEV_ID)) ||
                           (r_cmd_sr[2] && !r_cmd_sr[1])) && !(r_cmd_sr[2] && r_cmd_sr[1]);
  assign w_sel_read     = w_sel & r_cmd_sr[1];
  assign w_cmd_inrange  = {1'b0, w_cmd_addr} < NREGS;
  assign w_cmd_rdata    = w_cmd_inrange ? r_regs[w_cmd_addr[AW-1:0]] : 16'h0000;
  assign w_host_inrange = {1'b0, host_addr} < NREGS;
  assign host_rdata     = w_host_inrange ? r_regs[host_addr[AW-1:0]] : 16'h0000;
  assign w_unused       = r_cmd_sr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_abort      = 1'b0;
    w_end        = 1'b0;
    w_shift_cmd  = 1'b0;
    w_shift_data = 1'b0;
    w_decode     = 1'b0;
    w_tx_shift   = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_assert && r_armed) begin
          w_start      = 1'b1;
          w_state_next = CMD;
        end
      end
      CMD: begin
        if (w_cs_deassert) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end else if (r_bit_cnt == 6'd16) begin
          w_decode     = 1'b1;
          w_state_next = w_sel ? DATA : WAIT_CS;
        end else begin
          w_shift_cmd  = w_rise;
        end
      end
      DATA: begin
        if (w_cs_deassert) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end else if (r_bit_cnt == 6'd32) begin
          w_commit     = !r_is_read && w_cmd_inrange;
          w_state_next = WAIT_CS;
        end else begin
          w_shift_data = w_rise;
          w_tx_shift   = w_fall & r_is_read;
        end
      end
      WAIT_CS: begin
        if (w_cs_deassert) begin
          w_end        = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
      r_init_cnt  <= 8'd0;
      r_armed     <= 1'b0;
      r_bit_cnt   <= 6'd0;
      r_cmd_sr    <= 16'h0000;
      r_rx_sr     <= 16'h0000;
      r_tx_sr     <= 16'h0000;
      r_is_read   <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= 8'h00;
      wr_data     <= 16'h0000;
      rd_strobe   <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 16'h0000;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sclk_prev <= w_sclk;
      r_cs_prev   <= w_cs_n;
      // Arm only once a genuinely high CS has been seen, so a CS held low across reset is ignored.
      if (r_init_cnt != INIT_CYC) r_init_cnt <= r_init_cnt + 8'd1;
      else if (w_cs_n && r_cs_prev) r_armed <= 1'b1;

      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      frame_err <= w_abort;

      if (w_start) begin
        r_bit_cnt   <= 6'd0;
        r_cmd_sr    <= 16'h0000;
        r_rx_sr     <= 16'h0000;
        r_tx_sr     <= 16'h0000;
        r_is_read   <= 1'b0;
        busy        <= 1'b1;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end
      if (w_abort || w_end) begin
        busy        <= 1'b0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end
      if (w_shift_cmd) begin
        r_cmd_sr  <= {r_cmd_sr[14:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + 6'd1;
      end
      if (w_shift_data) begin
        r_rx_sr <= {r_rx_sr[14:0], w_mosi};
        if (r_bit_cnt != 6'd32) r_bit_cnt <= r_bit_cnt + 6'd1;
      end
      if (w_decode) begin
        r_is_read <= w_sel_read;
        if (w_sel_read) begin
          r_tx_sr     <= w_cmd_rdata;
          rd_strobe   <= w_cmd_inrange;
          spi_miso_oe <= 1'b1;
        end
      end
      if (w_tx_shift) begin
        spi_miso <= r_tx_sr[15];
        r_tx_sr  <= {r_tx_sr[14:0], 1'b0};
      end
      if (w_commit) begin
        r_regs[w_cmd_addr[AW-1:0]] <= r_rx_sr;
        wr_addr   <= w_cmd_addr;
        wr_data   <= r_rx_sr;
        wr_strobe <= 1'b1;
      end
    end
  end

endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
SPI Mode-0 (CPOL=0, CPHA=0) peripheral that consumes the 32-clock frames issued by the team's SPI master. Each frame is a 16b command followed by 16b data.
- Decodes the command and matches the 3-bit device ID.
- Performs register writes into a local 16-bit register file, or returns register contents on MISO.
- SCLK/MOSI/CS_N are oversampled in the system clock domain.
- The local side gets a read port plus write and read strobes.

Parameters:
DEV_ID, 3'd0, device ID this slave answers to (cmd[13:11]).
NUM_REGS, 16, number of 16-bit registers (1..256); addresses >= NUM_REGS are out of range.
SYNC_STAGES, 2, synchroniser depth for spi_sclk/spi_mosi/spi_cs_n (>=2).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
spi_sclk  input  1  SPI clock from master, idle low.
spi_mosi  input  1  master-out data, MSB first.
spi_cs_n  input  1  this slave's active-low chip select.
spi_miso  output  1  slave-out data, MSB first.
spi_miso_oe  output  1  high while this slave is driving a read data phase.
host_addr  input  8  local read address.
host_rdata  output  16  combinational reg[host_addr]; 0 if out of range.
wr_strobe  output  1  one-cycle pulse when an SPI write commits.
wr_addr  output  8  address of the last committed write.
wr_data  output  16  data of the last committed write.
rd_strobe  output  1  one-cycle pulse when a valid SPI read is decoded.
frame_err  output  1  one-cycle pulse when CS deasserts mid-frame.
busy  output  1  high from CS assert until CS deassert.

Behaviour:
- Reset values: all registers 0; spi_miso, spi_miso_oe, wr_strobe, rd_strobe, frame_err and busy are 0; wr_addr=0, wr_data=0; state IDLE; all synchroniser flops reset to the idle values (sclk=0, cs_n=1).
- Synchronisation and edge detection:
  - Inputs pass through SYNC_STAGES flops.
  - rise/fall/cs_assert/cs_deassert are single-cycle events derived from the synced value and its previous sample.
  - Required margin: SCLK half-period >= SYNC_STAGES+2 clk.
- Command format: [15:14] must be 00; [13:11]=ID; [10:3]=ADDR; [2]=GLOBAL; [1]=READ; [0] is reserved and ignored.
- States: IDLE, CMD, DATA, WAIT_CS.
  - IDLE: on cs_assert, clear bit counter and shifters, set busy=1, go to CMD. A CS that is already low when reset releases is ignored until it goes high and then low again.
  - CMD: on each rise, shift synced MOSI into cmd_sr. On the 16th rise, decode the next cycle:
    - Frame is selected if ([15:14]==00) and (ID==DEV_ID), or if (GLOBAL=1 and READ=0).
    - Selected read: requires GLOBAL=0. Load tx_sr=reg[ADDR], or 0 if out of range. Pulse rd_strobe for in-range addresses only. Set spi_miso_oe=1.
    - Unselected frame (including a global read): go to WAIT_CS; MISO stays 0 and oe stays 0.
    - Selected frames go to DATA.
  - DATA read: on each fall, spi_miso<=tx_sr[15] and tx_sr<<=1. The first fall after the 16th rise presents bit 15, so the master samples bit 15 on rise 17 and bit 0 on rise 32. After rise 32, go to WAIT_CS.
  - DATA write: on each rise, shift MOSI into rx_sr. On rise 32, in the next cycle:
    - In range: reg[ADDR]<=rx_sr, wr_addr<=ADDR, wr_data<=rx_sr, pulse wr_strobe.
    - Out of range: write is dropped and no strobe.
    - Then go to WAIT_CS.
  - WAIT_CS: extra SCLK edges are ignored. On cs_deassert: busy=0, miso=0, oe=0, go to IDLE.
- cs_deassert in CMD or DATA: pulse frame_err, no register update, no wr_strobe, go to IDLE in that cycle. cs_deassert has priority over a simultaneous rise/fall.
- Bit counter is 6 bits and saturates at 32.
- Reset mid-frame: immediate return to reset state; the frame is lost, with no partial write.
- Host read and SPI write to the same address in the same cycle: host_rdata shows the old value that cycle and the new value the next cycle.

Test Plan:
1. Write, DEV_ID=0: cmd 16'h0050 (ADDR 0x0A, write), data 16'hBEEF -> one wr_strobe, wr_addr=0x0A, wr_data=BEEF; host_addr=0x0A reads BEEF.
2. Read: preload reg 0x05=16'h1234 via SPI write, then cmd 16'h002A (ADDR 0x05, READ) -> rd_strobe once; MISO sampled at rises 17..32 is 0x1234; oe high only in that frame; master data_read_out=1234.
3. ID mismatch: cmd 16'h0850 (ID=1), data 16'h5555 -> no strobe, reg 0x0A unchanged, oe stays 0. Same frame with GLOBAL=1 (16'h0854) -> write commits.
4. Out of range: write to ADDR 0x20 with NUM_REGS=16 -> no wr_strobe, regs unchanged; read of 0x20 returns 0x0000, no rd_strobe.
5. Abort: deassert CS after 20 SCLK rises of a write to 0x03 -> frame_err pulses once, reg 0x03 unchanged, busy=0. The next full frame works normally.
6. Reset: assert rst_n low at rise 24 of a write -> all outputs 0, regs 0. CS still low after release -> ignored until a fresh CS falling edge.
